// File: rtl/csr_responder_pkg.sv
// Shared types and constants for the machine-mode CSR responder.
package csr_responder_pkg;

    // VSETVL, VSETVLMAX and VLEFF all arrive as CSR_CMD_VCFG; none is owned here.
    typedef enum logic [2:0] {
        CSR_CMD_NOPE  = 3'd0,
        CSR_CMD_READ  = 3'd1,
        CSR_CMD_WRITE = 3'd2,
        CSR_CMD_RW    = 3'd3,
        CSR_CMD_SET   = 3'd4,
        CSR_CMD_CLEAR = 3'd5,
        CSR_CMD_SYS   = 3'd6,
        CSR_CMD_VCFG  = 3'd7
    } csr_cmd_t;

    typedef enum logic {RUN = 1'b0, WFI = 1'b1} csr_resp_state_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] rdata;
        logic        xcpt;
        logic        eret;
        logic [63:0] evec;
        logic [63:0] cause;
    } csr_resp_t;

    localparam logic [11:0] CSR_FFLAGS   = 12'h001;
    localparam logic [11:0] CSR_FRM      = 12'h002;
    localparam logic [11:0] CSR_FCSR     = 12'h003;
    localparam logic [11:0] CSR_VXSAT    = 12'h009;
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;

    localparam logic [11:0] SYS_ECALL  = 12'h000;
    localparam logic [11:0] SYS_EBREAK = 12'h001;
    localparam logic [11:0] SYS_MRET   = 12'h302;
    localparam logic [11:0] SYS_WFI    = 12'h105;

    localparam logic [63:0] CAUSE_ILLEGAL = 64'd2;
    localparam logic [63:0] CAUSE_BREAK   = 64'd3;
    localparam logic [63:0] CAUSE_ECALL_M = 64'd11;

    function automatic logic [1:0] popcount2(input logic [1:0] m);
        return {1'b0, m[0]} + {1'b0, m[1]};
    endfunction

endpackage

// File: rtl/csr_responder_counter.sv
// Free-running counter with a 0..2 increment and a write port that wins over it.
module csr_counter #(
    parameter int CNT_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       inc_i,
    input  logic             we_i,
    input  logic [CNT_W-1:0] wdata_i,
    output logic [CNT_W-1:0] value_o
);

    // Write overrides the increment in the same cycle; wraps naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     value_o <= '0;
        else if (we_i) value_o <= wdata_i;
        else           value_o <= value_o + CNT_W'(inc_i);
    end

endmodule

// File: rtl/csr_responder.sv
// Machine-mode CSR responder: executes CSR ops, SYS ops and trap entry at commit.
module csr_responder
    import csr_responder_pkg::*;
#(
    parameter logic [63:0] MTVEC_RESET = 64'h100,
    parameter int          CNT_W       = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  csr_rw_cmd_i,
    input  logic [11:0] csr_rw_addr_i,
    input  logic [63:0] csr_rw_data_i,
    input  logic [1:0]  csr_retire_i,
    input  logic        csr_exception_i,
    input  logic [63:0] csr_xcpt_cause_i,
    input  logic [63:0] csr_pc_i,
    input  logic [4:0]  fp_status_i,
    input  logic        freg_modified_i,
    input  logic        csr_vxsat_i,
    input  logic        irq_i,
    output logic        resp_valid_o,
    output logic [63:0] resp_rdata_o,
    output logic        resp_xcpt_o,
    output logic        resp_eret_o,
    output logic [63:0] resp_evec_o,
    output logic [63:0] resp_cause_o,
    output logic        stall_o,
    output logic        irq_pending_o,
    output logic [2:0]  frm_o,
    output logic [1:0]  fs_o
);

    csr_resp_state_t state;
    csr_resp_t       resp;
    logic            stall, irq_pending;

    logic [63:0] mtvec, mscratch, mepc, mcause;
    logic        mie, mpie, vxsat;
    logic [1:0]  fs;
    logic [4:0]  fflags;
    logic [2:0]  frm;
    logic [CNT_W-1:0] mcycle, minstret;

    csr_cmd_t    cmd;
    logic        run, mapped, is_csr, is_wr, is_sys, illegal, trap;
    logic        sys_ecall, sys_ebreak, sys_mret, sys_wfi, mret_go, wfi_go, do_wr;
    logic        we_mstatus, we_mtvec, we_mscratch, we_mepc, we_mcause;
    logic        we_fflags, we_frm, we_fcsr, we_vxsat, we_mcycle, we_minstret, fp_dirty;
    logic [63:0] old, wval, cause, mstatus;
    logic [4:0]  fflags_next;
    logic [2:0]  frm_next;
    logic [1:0]  ret_inc;

    assign cmd     = csr_cmd_t'(csr_rw_cmd_i);
    assign run     = (state == RUN);
    assign mstatus = {49'd0, fs, 5'd0, mpie, 3'd0, mie, 3'd0};

    // Read mux: old value of the addressed CSR and whether the address exists.
    always_comb begin
        mapped = 1'b1;
        old    = '0;
        case (csr_rw_addr_i)
            CSR_FFLAGS:               old = {59'd0, fflags};
            CSR_FRM:                  old = {61'd0, frm};
            CSR_FCSR:                 old = {56'd0, frm, fflags};
            CSR_VXSAT:                old = {63'd0, vxsat};
            CSR_MSTATUS:              old = mstatus;
            CSR_MTVEC:                old = mtvec;
            CSR_MSCRATCH:             old = mscratch;
            CSR_MEPC:                 old = mepc;
            CSR_MCAUSE:               old = mcause;
            CSR_MCYCLE, CSR_CYCLE:    old = 64'(mcycle);
            CSR_MINSTRET, CSR_INSTRET: old = 64'(minstret);
            default:                  mapped = 1'b0;
        endcase
    end

    // Command decode, trap detection and write-value formation.
    always_comb begin
        is_csr     = cmd inside {CSR_CMD_READ, CSR_CMD_WRITE, CSR_CMD_RW, CSR_CMD_SET, CSR_CMD_CLEAR};
        is_wr      = cmd inside {CSR_CMD_WRITE, CSR_CMD_RW, CSR_CMD_SET, CSR_CMD_CLEAR};
        is_sys     = (cmd == CSR_CMD_SYS);
        sys_ecall  = is_sys && (csr_rw_addr_i == SYS_ECALL);
        sys_ebreak = is_sys && (csr_rw_addr_i == SYS_EBREAK);
        sys_mret   = is_sys && (csr_rw_addr_i == SYS_MRET);
        sys_wfi    = is_sys && (csr_rw_addr_i == SYS_WFI);
        illegal    = (is_csr && (!mapped || (is_wr && csr_rw_addr_i[11:10] == 2'b11)))
                   || (cmd == CSR_CMD_VCFG)
                   || (is_sys && !(sys_ecall || sys_ebreak || sys_mret || sys_wfi));
        // A commit exception takes priority and silences whatever rode with it.
        trap       = csr_exception_i || illegal || sys_ecall || sys_ebreak;
        if (csr_exception_i) cause = csr_xcpt_cause_i;
        else if (illegal)    cause = CAUSE_ILLEGAL;
        else if (sys_ecall)  cause = CAUSE_ECALL_M;
        else                 cause = CAUSE_BREAK;
        mret_go = run && sys_mret && !csr_exception_i;
        wfi_go  = run && sys_wfi && !csr_exception_i;
        do_wr   = run && is_wr && !trap;
        case (cmd)
            CSR_CMD_SET:   wval = old | csr_rw_data_i;
            CSR_CMD_CLEAR: wval = old & ~csr_rw_data_i;
            default:       wval = csr_rw_data_i;
        endcase
        we_mstatus  = do_wr && (csr_rw_addr_i == CSR_MSTATUS);
        we_mtvec    = do_wr && (csr_rw_addr_i == CSR_MTVEC);
        we_mscratch = do_wr && (csr_rw_addr_i == CSR_MSCRATCH);
        we_mepc     = do_wr && (csr_rw_addr_i == CSR_MEPC);
        we_mcause   = do_wr && (csr_rw_addr_i == CSR_MCAUSE);
        we_fflags   = do_wr && (csr_rw_addr_i == CSR_FFLAGS);
        we_frm      = do_wr && (csr_rw_addr_i == CSR_FRM);
        we_fcsr     = do_wr && (csr_rw_addr_i == CSR_FCSR);
        we_vxsat    = do_wr && (csr_rw_addr_i == CSR_VXSAT);
        we_mcycle   = do_wr && (csr_rw_addr_i == CSR_MCYCLE);
        we_minstret = do_wr && (csr_rw_addr_i == CSR_MINSTRET);
        // Retiring FP flags accumulate on top of any same-cycle software write.
        fflags_next = (we_fflags || we_fcsr) ? wval[4:0] : fflags;
        if (csr_retire_i != 2'b00) fflags_next = fflags_next | fp_status_i;
        frm_next    = we_frm ? wval[2:0] : (we_fcsr ? wval[7:5] : frm);
        fp_dirty    = freg_modified_i || (fp_status_i != 5'd0) || we_fflags || we_frm || we_fcsr;
        ret_inc     = (run && !csr_exception_i) ? popcount2(csr_retire_i) : 2'd0;
    end

    // Architectural CSR state; frozen while waiting for an interrupt.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtvec <= MTVEC_RESET; mscratch <= '0; mepc <= '0; mcause <= '0;
            mie <= 1'b0; mpie <= 1'b0; fs <= 2'b00;
            fflags <= '0; frm <= '0; vxsat <= 1'b0; irq_pending <= 1'b0;
        end else begin
            irq_pending <= irq_i && mie;
            if (run) begin
                if (we_mscratch) mscratch <= wval;
                if (we_mtvec)    mtvec    <= {wval[63:2], 2'b00};
                if (we_mepc)     mepc     <= {wval[63:1], 1'b0};
                if (we_mcause)   mcause   <= wval;
                if (we_mstatus) begin
                    mie <= wval[3]; mpie <= wval[7]; fs <= wval[14:13];
                end
                if (fp_dirty) fs <= 2'b11;
                if (trap) begin
                    mepc <= {csr_pc_i[63:1], 1'b0}; mcause <= cause;
                    mpie <= mie; mie <= 1'b0;
                end else if (mret_go) begin
                    mie <= mpie; mpie <= 1'b1;
                end
                fflags <= fflags_next;
                frm    <= frm_next;
                if (csr_vxsat_i)   vxsat <= 1'b1;
                else if (we_vxsat) vxsat <= wval[0];
            end
        end
    end

    // RUN/WFI sequencer with the registered commit response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= RUN; stall <= 1'b0; resp <= '0;
        end else begin
            resp <= '0;
            case (state)
                RUN: if (cmd != CSR_CMD_NOPE || csr_exception_i) begin
                    resp.valid <= 1'b1;
                    resp.rdata <= (is_csr && !trap) ? old : 64'd0;
                    resp.xcpt  <= trap;
                    resp.eret  <= mret_go;
                    resp.evec  <= trap ? mtvec : (mret_go ? mepc : 64'd0);
                    resp.cause <= trap ? cause : 64'd0;
                    if (wfi_go) begin state <= WFI; stall <= 1'b1; end
                end
                WFI: if (irq_i) begin state <= RUN; stall <= 1'b0; end
                default: begin state <= RUN; stall <= 1'b0; end
            endcase
        end
    end

    csr_counter #(.CNT_W(CNT_W)) u_mcycle (
        .clk_i(clk_i), .rst_i(rst_i), .inc_i(2'd1),
        .we_i(we_mcycle), .wdata_i(wval[CNT_W-1:0]), .value_o(mcycle)
    );

    csr_counter #(.CNT_W(CNT_W)) u_minstret (
        .clk_i(clk_i), .rst_i(rst_i), .inc_i(ret_inc),
        .we_i(we_minstret), .wdata_i(wval[CNT_W-1:0]), .value_o(minstret)
    );

    assign resp_valid_o  = resp.valid;
    assign resp_rdata_o  = resp.rdata;
    assign resp_xcpt_o   = resp.xcpt;
    assign resp_eret_o   = resp.eret;
    assign resp_evec_o   = resp.evec;
    assign resp_cause_o  = resp.cause;
    assign stall_o       = stall;
    assign irq_pending_o = irq_pending;
    assign frm_o         = frm;
    assign fs_o          = fs;

endmodule

// File: tb/tb_csr_responder.sv
// Directed + randomized bench for csr_responder against an address-keyed CSR model.
module tb_csr_responder;
    import csr_responder_pkg::*;

    localparam logic [63:0] MTV = 64'h100;

    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic [2:0]  cmd;
    logic [11:0] addr;
    logic [63:0] data, xcause, pc;
    logic [1:0]  retire;
    logic        exc, freg, vx, irq;
    logic [4:0]  fps;
    logic        resp_valid_o, resp_xcpt_o, resp_eret_o, stall_o, irq_pending_o;
    logic [63:0] resp_rdata_o, resp_evec_o, resp_cause_o;
    logic [2:0]  frm_o;
    logic [1:0]  fs_o;

    csr_responder #(.MTVEC_RESET(MTV), .CNT_W(64)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .csr_rw_cmd_i(cmd), .csr_rw_addr_i(addr), .csr_rw_data_i(data),
        .csr_retire_i(retire), .csr_exception_i(exc), .csr_xcpt_cause_i(xcause),
        .csr_pc_i(pc), .fp_status_i(fps), .freg_modified_i(freg),
        .csr_vxsat_i(vx), .irq_i(irq),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
        .resp_xcpt_o(resp_xcpt_o), .resp_eret_o(resp_eret_o),
        .resp_evec_o(resp_evec_o), .resp_cause_o(resp_cause_o),
        .stall_o(stall_o), .irq_pending_o(irq_pending_o),
        .frm_o(frm_o), .fs_o(fs_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0, n_bad = 0;

    // Model: architectural CSRs keyed by address; fcsr/cycle/instret are views.
    longint unsigned m_csr [int];
    bit              m_wfi;
    bit              e_valid, e_xcpt, e_eret, e_stall, e_irq;
    longint unsigned e_rdata, e_evec, e_cause;
    logic [2:0]      e_frm;
    logic [1:0]      e_fs;

    task automatic model_reset();
        m_csr.delete();
        m_csr['h300] = 0; m_csr['h305] = MTV; m_csr['h340] = 0; m_csr['h341] = 0;
        m_csr['h342] = 0; m_csr['hB00] = 0; m_csr['hB02] = 0;
        m_csr[1] = 0; m_csr[2] = 0; m_csr[9] = 0;
        m_wfi = 0;
    endtask

    function automatic bit m_mapped(int a);
        return a inside {1, 2, 3, 9, 'h300, 'h305, 'h340, 'h341, 'h342, 'hB00, 'hB02, 'hC00, 'hC02};
    endfunction

    function automatic longint unsigned m_read(int a);
        case (a)
            3:       return (m_csr[2] << 5) | m_csr[1];
            'hC00:   return m_csr['hB00];
            'hC02:   return m_csr['hB02];
            default: return m_csr[a];
        endcase
    endfunction

    task automatic m_write(int a, longint unsigned v);
        case (a)
            1:       m_csr[1] = v & 'h1f;
            2:       m_csr[2] = v & 'h7;
            3:       begin m_csr[1] = v & 'h1f; m_csr[2] = (v >> 5) & 'h7; end
            9:       m_csr[9] = v & 'h1;
            'h300:   m_csr['h300] = v & 'h6088;
            'h305:   m_csr['h305] = v & ~64'h3;
            'h341:   m_csr['h341] = v & ~64'h1;
            default: m_csr[a] = v;
        endcase
    endtask

    // Apply one clock edge to the model from the current inputs.
    task automatic model_edge();
        int              a;
        bit              trap, mret, wfi, dirty, wr_cyc, wr_ins;
        longint unsigned cs, old, nv, ms, tmp;
        a = int'(addr);
        trap = 0; mret = 0; wfi = 0; dirty = 0; wr_cyc = 0; wr_ins = 0; cs = 0;
        ms = m_csr['h300];
        e_irq = irq && ms[3];
        e_valid = 0; e_rdata = 0; e_xcpt = 0; e_eret = 0; e_evec = 0; e_cause = 0;
        if (m_wfi) begin
            if (irq) m_wfi = 0;
        end else begin
            if (exc) begin trap = 1; cs = xcause; end
            else if (cmd == 3'd7) begin trap = 1; cs = 2; end
            else if (cmd == 3'd6) begin
                case (a)
                    0:       begin trap = 1; cs = 11; end
                    1:       begin trap = 1; cs = 3; end
                    'h302:   mret = 1;
                    'h105:   wfi = 1;
                    default: begin trap = 1; cs = 2; end
                endcase
            end else if (cmd >= 3'd1 && cmd <= 3'd5) begin
                if (!m_mapped(a) || (cmd != 3'd1 && addr[11:10] == 2'b11)) begin
                    trap = 1; cs = 2;
                end else begin
                    old = m_read(a);
                    e_rdata = old;
                    if (cmd != 3'd1) begin
                        nv = (cmd == 3'd4) ? (old | data) : (cmd == 3'd5) ? (old & ~data) : data;
                        m_write(a, nv);
                        wr_cyc = (a == 'hB00);
                        wr_ins = (a == 'hB02);
                        dirty  = a inside {1, 2, 3};
                    end
                end
            end
            e_valid = (cmd != 3'd0) || exc;
            if (trap) begin
                e_xcpt = 1; e_evec = m_csr['h305]; e_cause = cs;
                m_csr['h341] = pc & ~64'h1; m_csr['h342] = cs;
                ms = m_csr['h300]; ms[7] = ms[3]; ms[3] = 0; m_csr['h300] = ms;
            end
            if (mret) begin
                e_eret = 1; e_evec = m_csr['h341];
                ms = m_csr['h300]; ms[3] = ms[7]; ms[7] = 1; m_csr['h300] = ms;
            end
            if (wfi) m_wfi = 1;
            if (retire != 0) m_csr[1] = m_csr[1] | 64'(fps);
            if (freg || fps != 0 || dirty) m_csr['h300] = m_csr['h300] | 'h6000;
            if (vx) m_csr[9] = 1;
            if (!exc && !wr_ins) m_csr['hB02] = m_csr['hB02] + 64'($countones(retire));
        end
        if (!wr_cyc) m_csr['hB00] = m_csr['hB00] + 1;
        e_stall = m_wfi;
        tmp = m_csr[2];          e_frm = tmp[2:0];
        tmp = m_csr['h300];      e_fs  = tmp[14:13];
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk_i); #1;
        chk({tag, ".valid"}, 64'(resp_valid_o), 64'(e_valid));
        chk({tag, ".rdata"}, resp_rdata_o, e_rdata);
        chk({tag, ".xcpt"},  64'(resp_xcpt_o), 64'(e_xcpt));
        chk({tag, ".eret"},  64'(resp_eret_o), 64'(e_eret));
        chk({tag, ".evec"},  resp_evec_o, e_evec);
        chk({tag, ".cause"}, resp_cause_o, e_cause);
        chk({tag, ".stall"}, 64'(stall_o), 64'(e_stall));
        chk({tag, ".irqp"},  64'(irq_pending_o), 64'(e_irq));
        chk({tag, ".frm"},   64'(frm_o), 64'(e_frm));
        chk({tag, ".fs"},    64'(fs_o), 64'(e_fs));
    endtask

    task automatic idle();
        cmd = 3'd0; addr = '0; data = '0; retire = '0; exc = 0; xcause = '0;
        pc = '0; fps = '0; freg = 0; vx = 0; irq = 0;
    endtask

    task automatic req(input logic [2:0] c, input logic [11:0] a, input logic [63:0] d);
        cmd = c; addr = a; data = d;
    endtask

    logic [11:0] alist [14] = '{12'h001, 12'h002, 12'h003, 12'h009, 12'h300, 12'h305, 12'h340,
                                12'h341, 12'h342, 12'hB00, 12'hB02, 12'hC00, 12'hC02, 12'h7FF};
    logic [11:0] slist [4]  = '{12'h000, 12'h001, 12'h302, 12'h7FF};
    logic [63:0] r0;

    initial begin
        idle();
        model_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst.valid", 64'(resp_valid_o), 64'd0);
        chk("rst.rdata", resp_rdata_o, 64'd0);
        chk("rst.evec",  resp_evec_o, 64'd0);
        chk("rst.stall", 64'(stall_o), 64'd0);
        chk("rst.fs",    64'(fs_o), 64'd0);
        rst_i = 1'b0;

        // CSRRW swaps on mscratch
        req(CSR_CMD_RW, CSR_MSCRATCH, 64'hDEAD); step("rw1");
        req(CSR_CMD_RW, CSR_MSCRATCH, 64'hBEEF); step("rw2");
        chk("rw2.old", resp_rdata_o, 64'hDEAD);
        req(CSR_CMD_READ, CSR_MSCRATCH, 0); step("rd_scr");
        chk("rd_scr.val", resp_rdata_o, 64'hBEEF);

        // Enable MIE, then take a commit exception
        req(CSR_CMD_SET, CSR_MSTATUS, 64'h8); step("set_mie");
        idle(); exc = 1; xcause = 64'd5; pc = 64'h2000; step("exc5");
        chk("exc5.xcpt", 64'(resp_xcpt_o), 64'd1);
        chk("exc5.evec", resp_evec_o, MTV);
        chk("exc5.cause", resp_cause_o, 64'd5);
        idle(); req(CSR_CMD_READ, CSR_MEPC, 0); step("rd_mepc");
        chk("mepc.val", resp_rdata_o, 64'h2000);
        req(CSR_CMD_READ, CSR_MCAUSE, 0); step("rd_mcause");
        chk("mcause.val", resp_rdata_o, 64'd5);
        req(CSR_CMD_READ, CSR_MSTATUS, 0); step("rd_mst1");
        chk("mst.after_trap", resp_rdata_o, 64'h80);

        // MRET back to mepc
        req(CSR_CMD_SYS, SYS_MRET, 0); step("mret");
        chk("mret.eret", 64'(resp_eret_o), 64'd1);
        chk("mret.evec", resp_evec_o, 64'h2000);
        req(CSR_CMD_READ, CSR_MSTATUS, 0); step("rd_mst2");
        chk("mst.after_mret", resp_rdata_o, 64'h88);

        // Illegal accesses: read-only space, unmapped, vector config
        req(CSR_CMD_READ, CSR_CYCLE, 0); step("rd_cyc0");
        r0 = resp_rdata_o;
        req(CSR_CMD_WRITE, CSR_CYCLE, 64'h0); step("wr_cyc");
        chk("wr_cyc.cause", resp_cause_o, 64'd2);
        req(CSR_CMD_READ, CSR_CYCLE, 0); step("rd_cyc1");
        chk("cyc.advance", resp_rdata_o, r0 + 64'd2);
        req(CSR_CMD_RW, 12'h7FF, 64'h1); step("rw_7ff");
        chk("rw_7ff.cause", resp_cause_o, 64'd2);
        req(CSR_CMD_VCFG, 12'h000, 64'h0); step("vcfg");
        chk("vcfg.cause", resp_cause_o, 64'd2);

        // minstret accumulation and write override
        req(CSR_CMD_READ, CSR_MINSTRET, 0); step("rd_ins0");
        r0 = resp_rdata_o;
        idle(); retire = 2'b11;
        for (int i = 0; i < 10; i++) step("ret2");
        retire = 2'b00; req(CSR_CMD_READ, CSR_MINSTRET, 0); step("rd_ins1");
        chk("minstret.plus20", resp_rdata_o, r0 + 64'd20);
        req(CSR_CMD_WRITE, CSR_MINSTRET, 64'd5); retire = 2'b01; step("wr_ins");
        retire = 2'b00; req(CSR_CMD_READ, CSR_MINSTRET, 0); step("rd_ins2");
        chk("minstret.wr", resp_rdata_o, 64'd5);

        // WFI: stalls, ignores requests, leaves on irq
        req(CSR_CMD_SYS, SYS_WFI, 0); step("wfi");
        chk("wfi.stall", 64'(stall_o), 64'd1);
        req(CSR_CMD_WRITE, CSR_MSCRATCH, 64'h1234);
        for (int i = 0; i < 4; i++) step("wfi_hold");
        idle(); irq = 1; step("wfi_wake");
        chk("wake.stall", 64'(stall_o), 64'd0);
        idle(); req(CSR_CMD_READ, CSR_MSCRATCH, 0); step("rd_scr2");
        chk("wfi.ignored", resp_rdata_o, 64'hBEEF);

        // FP flags accumulate and dirty FS
        idle(); fps = 5'h1; retire = 2'b01; step("fp");
        idle(); req(CSR_CMD_READ, CSR_FFLAGS, 0); step("rd_ff");
        chk("fflags.val", resp_rdata_o, 64'd1);
        chk("fs.dirty", 64'(fs_o), 64'd3);

        // Reset in the middle of WFI with a live response
        req(CSR_CMD_SYS, SYS_WFI, 0); step("wfi2");
        idle(); #2; rst_i = 1'b1; #1;
        chk("midrst.valid", 64'(resp_valid_o), 64'd0);
        chk("midrst.stall", 64'(stall_o), 64'd0);
        model_reset();
        @(posedge clk_i); #1; rst_i = 1'b0;
        req(CSR_CMD_READ, CSR_MTVEC, 0); step("rd_mtvec");
        chk("mtvec.reset", resp_rdata_o, MTV);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            idle();
            cmd = 3'($urandom_range(0, 7));
            if (cmd == 3'd6) addr = slist[$urandom_range(0, 3)];
            else             addr = alist[$urandom_range(0, 13)];
            data   = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 255));
            retire = 2'($urandom_range(0, 3));
            exc    = ($urandom_range(0, 15) == 0);
            xcause = 64'($urandom_range(0, 15));
            pc     = {$urandom, $urandom};
            fps    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd0;
            freg   = ($urandom_range(0, 7) == 0);
            vx     = ($urandom_range(0, 7) == 0);
            irq    = 1'($urandom_range(0, 1));
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
